// File: rtl/dequantize_stream_if.sv
// Stream bundle for the int8 -> int32 dequantizer: int8 beats in, int32 beats out,
// plus the output-side frame position and the sticky framing error.
interface dequantize_stream_if #(
   parameter int IDX_W = 4
);
   logic                    in_valid;
   logic                    in_ready;
   logic signed [7:0]       in_data;
   logic                    in_last;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [31:0]      out_data;
   logic                    out_last;
   logic [IDX_W-1:0]        out_idx;
   logic                    frame_err;

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_last, out_idx, frame_err
   );

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_last, out_idx, frame_err
   );
endinterface

// File: rtl/dequantize_stream.sv
// Three-stage int8 -> int32 dequantizer: subtract zero point, fixed-point multiply,
// round-half-up right shift with int32 saturation; output-side frame index tracking.
module dequantize_stream #(
   parameter int ZERO_POINT = 0,
   parameter int MULT_VAL   = 1,
   parameter int SHIFT_VAL  = 0,
   parameter int VEC_LEN    = 10,
   parameter int IDX_W      = 4
) (
   input  logic                clk,
   input  logic                rst,
   dequantize_stream_if.slave  io
);
   localparam int STAGES = 3;
   localparam logic signed [8:0]  ZP     = 9'(ZERO_POINT);
   localparam logic signed [47:0] MULT   = 48'(MULT_VAL);
   localparam int                 RND_SH = (SHIFT_VAL > 0) ? SHIFT_VAL - 1 : 0;
   localparam logic signed [48:0] RND    = (SHIFT_VAL > 0) ? (49'sd1 <<< RND_SH) : 49'sd0;
   localparam logic signed [48:0] MAX32  = 49'sd2147483647;
   localparam logic signed [48:0] MIN32  = -49'sd2147483648;
   localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(VEC_LEN - 1);

   logic [STAGES:1]   vld_pipe;
   logic [STAGES:1]   last_pipe;
   logic              adv1, adv2, adv3;
   logic signed [8:0]  s1_d;
   logic signed [47:0] s2_p;
   logic signed [31:0] s3_r;
   logic signed [8:0]  d_in;
   logic signed [48:0] rnd_sum;
   logic signed [48:0] shifted;
   logic signed [31:0] sat;
   logic [IDX_W-1:0]   cnt;
   logic               err;
   logic               out_xfer;

   // Ready ripples back combinationally so a full pipe still moves every cycle.
   assign adv3        = !vld_pipe[3] || io.out_ready;
   assign adv2        = !vld_pipe[2] || adv3;
   assign adv1        = !vld_pipe[1] || adv2;
   assign io.in_ready = adv1;
   assign out_xfer    = vld_pipe[3] && io.out_ready;

   always_comb begin
      d_in    = $signed({io.in_data[7], io.in_data}) - ZP;
      rnd_sum = 49'(s2_p) + RND;
      shifted = rnd_sum >>> SHIFT_VAL;
      if (shifted > MAX32)
         sat = 32'sh7FFF_FFFF;
      else if (shifted < MIN32)
         sat = 32'sh8000_0000;
      else
         sat = shifted[31:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe  <= '0;
         last_pipe <= '0;
         s1_d      <= '0;
         s2_p      <= '0;
         s3_r      <= '0;
         cnt       <= '0;
         err       <= 1'b0;
      end else begin
         if (adv1) begin
            vld_pipe[1] <= io.in_valid;
            if (io.in_valid) begin
               s1_d         <= d_in;
               last_pipe[1] <= io.in_last;
            end
         end
         if (adv2) begin
            vld_pipe[2] <= vld_pipe[1];
            if (vld_pipe[1]) begin
               s2_p         <= 48'(s1_d) * MULT;
               last_pipe[2] <= last_pipe[1];
            end
         end
         if (adv3) begin
            vld_pipe[3] <= vld_pipe[2];
            if (vld_pipe[2]) begin
               s3_r         <= sat;
               last_pipe[3] <= last_pipe[2];
            end
         end
         // A short frame or an overlong one both flag the error; the index restarts either way.
         if (out_xfer) begin
            if (last_pipe[3]) begin
               cnt <= '0;
               if (cnt != LAST_IDX) err <= 1'b1;
            end else if (cnt == LAST_IDX) begin
               cnt <= '0;
               err <= 1'b1;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

   assign io.out_valid = vld_pipe[3];
   assign io.out_data  = s3_r;
   assign io.out_last  = last_pipe[3];
   assign io.out_idx   = cnt;
   assign io.frame_err = err;
endmodule

// File: tb/tb_dequantize_stream.sv
// Directed bench: four parameterisations share one input stream for the arithmetic
// table; u0 alone is checked for backpressure, mid-stream reset and framing.
module tb_dequantize_stream;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   nvec = 0;
   int   errs = 0;

   always #5 clk = ~clk;

   dequantize_stream_if #(.IDX_W(4)) i0 (), i1 (), i2 (), i3 ();

   dequantize_stream #(.ZERO_POINT(0),  .MULT_VAL(1), .SHIFT_VAL(0), .VEC_LEN(10), .IDX_W(4))
      u0 (.clk(clk), .rst(rst), .io(i0.slave));
   dequantize_stream #(.ZERO_POINT(0),  .MULT_VAL(3), .SHIFT_VAL(1), .VEC_LEN(10), .IDX_W(4))
      u1 (.clk(clk), .rst(rst), .io(i1.slave));
   dequantize_stream #(.ZERO_POINT(0),  .MULT_VAL(2147483647), .SHIFT_VAL(0), .VEC_LEN(10), .IDX_W(4))
      u2 (.clk(clk), .rst(rst), .io(i2.slave));
   dequantize_stream #(.ZERO_POINT(10), .MULT_VAL(1), .SHIFT_VAL(0), .VEC_LEN(10), .IDX_W(4))
      u3 (.clk(clk), .rst(rst), .io(i3.slave));

   typedef struct {
      logic signed [7:0]  q;
      logic signed [31:0] e0;  // zp 0, mult 1, shift 0
      logic signed [31:0] e1;  // mult 3, shift 1
      logic signed [31:0] e2;  // mult 0x7FFFFFFF
      logic signed [31:0] e3;  // zp 10
   } vec_t;

   vec_t tbl [7];

   task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
      nvec++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic signed [7:0] d, input logic l);
      i0.in_valid = v; i0.in_data = d; i0.in_last = l;
      i1.in_valid = v; i1.in_data = d; i1.in_last = l;
      i2.in_valid = v; i2.in_data = d; i2.in_last = l;
      i3.in_valid = v; i3.in_data = d; i3.in_last = l;
   endtask

   task automatic set_ready(input logic r);
      i0.out_ready = r; i1.out_ready = r; i2.out_ready = r; i3.out_ready = r;
   endtask

   initial begin
      int k, acc, got;
      tbl[0] = '{q: -8'sd128, e0: -32'sd128, e1: -32'sd192, e2: -32'sd2147483648, e3: -32'sd138};
      tbl[1] = '{q:  8'sd0,   e0:  32'sd0,   e1:  32'sd0,   e2:  32'sd0,          e3: -32'sd10};
      tbl[2] = '{q:  8'sd127, e0:  32'sd127, e1:  32'sd191, e2:  32'sd2147483647, e3:  32'sd117};
      tbl[3] = '{q:  8'sd5,   e0:  32'sd5,   e1:  32'sd8,   e2:  32'sd2147483647, e3: -32'sd5};
      tbl[4] = '{q: -8'sd5,   e0: -32'sd5,   e1: -32'sd7,   e2: -32'sd2147483648, e3: -32'sd15};
      tbl[5] = '{q:  8'sd1,   e0:  32'sd1,   e1:  32'sd2,   e2:  32'sd2147483647, e3: -32'sd9};
      tbl[6] = '{q: -8'sd1,   e0: -32'sd1,   e1: -32'sd1,   e2: -32'sd2147483647, e3: -32'sd11};

      drive(1'b0, 8'sd0, 1'b0);
      set_ready(1'b1);

      // Reset state
      @(negedge clk);
      chk("rst_out_valid", i0.out_valid, 0);
      chk("rst_out_data",  i0.out_data,  0);
      chk("rst_out_last",  i0.out_last,  0);
      chk("rst_out_idx",   i0.out_idx,   0);
      chk("rst_frame_err", i0.frame_err, 0);
      chk("rst_in_ready",  i0.in_ready,  1);
      rst = 1'b0;

      // Arithmetic table, streamed back-to-back
      k = 0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (i0.out_valid) begin
            if (k < 7) begin
               chk("latency", c, k + 3);
               chk("u0_data", i0.out_data, tbl[k].e0);
               chk("u1_data", i1.out_data, tbl[k].e1);
               chk("u2_data", i2.out_data, tbl[k].e2);
               chk("u3_data", i3.out_data, tbl[k].e3);
            end
            k++;
         end
         if (c < 7) drive(1'b1, tbl[c].q, 1'b0);
         else       drive(1'b0, 8'sd0, 1'b0);
         #1;
         if (c < 7) chk("stream_in_ready", i0.in_ready, 1);
      end
      chk("stream_beats_out", k, 7);

      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;

      // Backpressure: pipe fills after 3 beats and holds the oldest at the output
      set_ready(1'b0);
      acc = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         drive(acc < 5, 8'(acc + 1), 1'b0);
         #1;
         if (i0.in_ready && acc < 5) acc++;
      end
      chk("bp_accepted",  acc, 3);
      chk("bp_in_ready",  i0.in_ready,  0);
      chk("bp_out_valid", i0.out_valid, 1);
      chk("bp_out_data",  i0.out_data,  1);
      got = 0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         set_ready(1'b1);
         if (i0.out_valid) begin
            chk("bp_drain_data", i0.out_data, got + 1);
            chk("bp_drain_idx",  i0.out_idx,  got);
            got++;
         end
         drive(acc < 5, 8'(acc + 1), 1'b0);
         #1;
         if (i0.in_ready && acc < 5) acc++;
      end
      chk("bp_total_out", got, 5);
      chk("bp_total_in",  acc, 5);

      // Reset with two beats in flight
      @(negedge clk); drive(1'b1, 8'sd50, 1'b0);
      @(negedge clk); drive(1'b1, 8'sd60, 1'b0);
      @(negedge clk); drive(1'b0, 8'sd0, 1'b0);
      rst = 1'b1;
      #1;
      chk("mid_rst_out_valid", i0.out_valid, 0);
      chk("mid_rst_out_data",  i0.out_data,  0);
      chk("mid_rst_out_idx",   i0.out_idx,   0);
      @(negedge clk); rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("post_rst_no_stale", i0.out_valid, 0);
      end

      // Framing: a proper 10-beat frame, a 7-beat short frame, then one more beat
      k = 0;
      for (int c = 0; c < 26; c++) begin
         @(negedge clk);
         if (i0.out_valid) begin
            chk("frm_idx",  i0.out_idx,   (k < 10) ? k : (k < 17) ? k - 10 : 0);
            chk("frm_err",  i0.frame_err, (k >= 17) ? 1 : 0);
            chk("frm_last", i0.out_last,  (k == 9 || k == 16) ? 1 : 0);
            chk("frm_data", i0.out_data,  k + 1);
            k++;
         end
         if (c < 18) drive(1'b1, 8'(c + 1), (c == 9 || c == 16));
         else        drive(1'b0, 8'sd0, 1'b0);
      end
      chk("frm_beats_out",  k, 18);
      chk("frm_err_sticky", i0.frame_err, 1);
      rst = 1'b1;
      #1;
      chk("frm_err_rst_clear", i0.frame_err, 0);
      @(negedge clk); rst = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
      $finish;
   end
endmodule
